// File: rtl/alu_share_arb.sv
// Two requesters share one combinational ALU through a round-robin arbiter.
// The result sits in a single output slot that drains through a valid/ready port.
module alu_share_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [WIDTH-1:0] s0_a,
  input  logic [WIDTH-1:0] s0_b,
  input  logic [1:0]       s0_sel,

  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [WIDTH-1:0] s1_a,
  input  logic [WIDTH-1:0] s1_b,
  input  logic [1:0]       s1_sel,

  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_y,
  output logic             m_id,

  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,

  output logic             dbg_state_o,
  output logic             dbg_rr_ptr_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. Valid never depends on ready; ready may depend on valid.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             id_q, id_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [7:0]       cnt0_q, cnt0_d;
  logic [7:0]       cnt1_q, cnt1_d;

  logic             slot_free;
  logic             acc0;
  logic             acc1;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] alu_y;

  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  always_comb begin
    slot_free = !rst && ((state_q == EMPTY) || m_ready);
    s0_ready  = slot_free && (!s1_valid || (rr_ptr_q == 1'b0));
    s1_ready  = slot_free && (!s0_valid || (rr_ptr_q == 1'b1));
    acc0      = s0_valid && s0_ready;
    acc1      = s1_valid && s1_ready;
  end

  always_comb begin
    op_a   = s0_a;
    op_b   = s0_b;
    op_sel = s0_sel;
    if (acc1) begin
      op_a   = s1_a;
      op_b   = s1_b;
      op_sel = s1_sel;
    end
  end

  always_comb begin
    alu_y = '0;
    case (op_sel)
      2'b00:   alu_y = op_a + op_b;
      2'b01:   alu_y = op_a - op_b;
      2'b10:   alu_y = op_a & op_b;
      default: alu_y = op_a | op_b;
    endcase
  end

  // Accept wins over drain, so a simultaneous drain+accept stays FULL.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    if (acc0 || acc1) begin
      state_d  = FULL;
      y_d      = alu_y;
      id_d     = acc1;
      rr_ptr_d = acc0;
      if (acc0) cnt0_d = cnt0_q + 8'd1;
      if (acc1) cnt1_d = cnt1_q + 8'd1;
    end else if ((state_q == FULL) && m_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      y_q      <= '0;
      id_q     <= 1'b0;
      rr_ptr_q <= 1'b0;
      cnt0_q   <= 8'd0;
      cnt1_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign m_valid      = (state_q == FULL);
  assign m_y          = y_q;
  assign m_id         = id_q;
  assign cnt0         = cnt0_q;
  assign cnt1         = cnt1_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: hand-computed vectors checked with
// immediate assertions one cycle after each accepting edge.
module tb_alu_share_arb;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             s0_valid, s1_valid;
  logic             s0_ready, s1_ready;
  logic [WIDTH-1:0] s0_a, s0_b, s1_a, s1_b;
  logic [1:0]       s0_sel, s1_sel;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_y;
  logic             m_id;
  logic [7:0]       cnt0, cnt1;
  logic             dbg_state;
  logic             dbg_rr_ptr;

  int errors = 0;
  int checks = 0;

  alu_share_arb #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .s0_valid     (s0_valid),
    .s0_ready     (s0_ready),
    .s0_a         (s0_a),
    .s0_b         (s0_b),
    .s0_sel       (s0_sel),
    .s1_valid     (s1_valid),
    .s1_ready     (s1_ready),
    .s1_a         (s1_a),
    .s1_b         (s1_b),
    .s1_sel       (s1_sel),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_y          (m_y),
    .m_id         (m_id),
    .cnt0         (cnt0),
    .cnt1         (cnt1),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr_ptr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_a = '0; s0_b = '0; s0_sel = 2'b00;
    s1_a = '0; s1_b = '0; s1_sel = 2'b00;
    m_ready = 1'b1;

    // Reset state, with a requester already valid
    tick();
    s0_valid = 1'b1;
    tick();
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_y", 32'(m_y), 32'd0);
    chk("rst_m_id", 32'(m_id), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_s0_ready", 32'(s0_ready), 32'd0);
    chk("rst_s1_ready", 32'(s1_ready), 32'd0);
    chk("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);

    // s0 only add, accepted on first edge after release
    tick();
    rst = 1'b0;
    s0_valid = 1'b1; s0_a = 16'd15; s0_b = 16'd4; s0_sel = 2'b00;
    #1;
    chk("first_s0_ready", 32'(s0_ready), 32'd1);
    tick();
    s0_valid = 1'b0;
    chk("add_valid", 32'(m_valid), 32'd1);
    chk("add_y", 32'(m_y), 32'd19);
    chk("add_id", 32'(m_id), 32'd0);
    chk("add_cnt0", 32'(cnt0), 32'd1);
    chk("add_rr", 32'(dbg_rr_ptr), 32'd1);

    // s1 only sub, granted even when rr_ptr points elsewhere
    s1_valid = 1'b1; s1_a = 16'd4; s1_b = 16'd15; s1_sel = 2'b01;
    tick();
    chk("sub_neg_y", 32'(m_y), 32'hFFF5);
    chk("sub_neg_id", 32'(m_id), 32'd1);
    chk("sub_neg_rr", 32'(dbg_rr_ptr), 32'd0);
    s1_a = 16'd15; s1_b = 16'd4;
    tick();
    chk("sub_pos_y", 32'(m_y), 32'd11);
    chk("sub_pos_id", 32'(m_id), 32'd1);
    chk("sub_cnt1", 32'(cnt1), 32'd2);
    s1_valid = 1'b0;
    tick();
    chk("drain_empty", 32'(m_valid), 32'd0);
    chk("drain_y_held", 32'(m_y), 32'd11);

    // Asynchronous reset pulse, then contention
    rst = 1'b1;
    #1;
    chk("pulse_cnt1", 32'(cnt1), 32'd0);
    rst = 1'b0;
    s0_valid = 1'b1; s0_a = 16'h0F0F; s0_b = 16'h00FF; s0_sel = 2'b10;
    s1_valid = 1'b1; s1_a = 16'h0F0F; s1_b = 16'h00FF; s1_sel = 2'b11;
    #1;
    chk("cont_s0_ready", 32'(s0_ready), 32'd1);
    chk("cont_s1_ready", 32'(s1_ready), 32'd0);
    tick();
    chk("cont1_y", 32'(m_y), 32'h000F);
    chk("cont1_id", 32'(m_id), 32'd0);
    tick();
    chk("cont2_y", 32'(m_y), 32'h0FFF);
    chk("cont2_id", 32'(m_id), 32'd1);
    tick();
    chk("cont3_id", 32'(m_id), 32'd0);
    tick();
    chk("cont4_id", 32'(m_id), 32'd1);
    chk("cont4_y", 32'(m_y), 32'h0FFF);
    chk("cont_cnt0", 32'(cnt0), 32'd2);
    chk("cont_cnt1", 32'(cnt1), 32'd2);

    // Backpressure: held result, no readiness, operand changes ignored
    m_ready = 1'b0;
    #1;
    chk("stall_s0_ready", 32'(s0_ready), 32'd0);
    chk("stall_s1_ready", 32'(s1_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      s0_a = 16'(i * 16'h1111); s1_b = 16'(i);
      tick();
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_y", 32'(m_y), 32'h0FFF);
      chk("stall_id", 32'(m_id), 32'd1);
    end
    chk("stall_cnt0", 32'(cnt0), 32'd2);

    // Drain and accept on the same edge
    s1_valid = 1'b0;
    s0_a = 16'h1234; s0_b = 16'h0001; s0_sel = 2'b00;
    m_ready = 1'b1;
    #1;
    chk("dra_s0_ready", 32'(s0_ready), 32'd1);
    tick();
    chk("dra_valid", 32'(m_valid), 32'd1);
    chk("dra_y", 32'(m_y), 32'h1235);
    chk("dra_id", 32'(m_id), 32'd0);
    chk("dra_cnt0", 32'(cnt0), 32'd3);

    // Reset while FULL and both requesters valid
    s1_valid = 1'b1;
    m_ready = 1'b0;
    tick();
    chk("pre_rst_full", 32'(m_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_y", 32'(m_y), 32'd0);
    chk("mid_rst_cnt0", 32'(cnt0), 32'd0);
    chk("mid_rst_cnt1", 32'(cnt1), 32'd0);
    chk("mid_rst_s0_ready", 32'(s0_ready), 32'd0);
    chk("mid_rst_s1_ready", 32'(s1_ready), 32'd0);
    rst = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("post_rst_valid1", 32'(m_valid), 32'd0);
    tick();
    chk("post_rst_valid2", 32'(m_valid), 32'd0);

    // 256 back-to-back s0 accepts: counter wrap
    s0_valid = 1'b1; s0_b = 16'd1; s0_sel = 2'b00;
    for (int i = 0; i < 256; i++) begin
      s0_a = 16'(i);
      tick();
      if (i == 254) chk("wrap_cnt0_255", 32'(cnt0), 32'd255);
      if (i == 100) chk("b2b_y", 32'(m_y), 32'd101);
    end
    s0_valid = 1'b0;
    chk("wrap_cnt0", 32'(cnt0), 32'd0);
    chk("wrap_cnt1", 32'(cnt1), 32'd0);
    chk("wrap_y", 32'(m_y), 32'h0100);
    chk("wrap_valid", 32'(m_valid), 32'd1);
    tick();
    chk("final_empty", 32'(m_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 s0_valid  input  1  requester 0 has an operation pending.
REQ-005 s0_ready  output  1  requester 0 operation accepted on this edge when s0_valid is also high.
REQ-006 s0_a, s0_b  input  WIDTH each  requester 0 operands.
REQ-007 s0_sel  input  2  requester 0 opcode: 00 add, 01 sub, 10 and, 11 or.
REQ-008 s1_valid, s1_ready, s1_a, s1_b, s1_sel  same widths and meanings as REQ-004..007, for requester 1.
REQ-009 m_valid  output  1  result register holds a valid result.
REQ-010 m_ready  input  1  downstream consumes the result on this edge when m_valid is high.
REQ-011 m_y  output  WIDTH  result.
REQ-012 m_id  output  1  index of the requester that issued the result.
REQ-013 cnt0, cnt1  output  8 each  count of operations accepted from requester 0 / 1.

Function
REQ-014 Block SHALL contain one combinational ALU, shared by both requesters: 00 a+b mod 2^WIDTH; 01 a-b mod 2^WIDTH (two's complement); 10 a&b; 11 a|b; carry/borrow discarded.
REQ-015 Output slot FSM SHALL have two states: EMPTY (m_valid=0) and FULL (m_valid=1).
REQ-016 slot_free SHALL be (state==EMPTY) or (state==FULL and m_ready=1).
REQ-017 s0_ready SHALL be slot_free and (s1_valid=0 or rr_ptr=0); s1_ready SHALL be slot_free and (s0_valid=0 or rr_ptr=1); never both accepted in one cycle.
REQ-018 Accept of requester i occurs on an edge where si_valid=1 and si_ready=1; on that edge m_y SHALL load the ALU result of si_a, si_b, si_sel, m_id SHALL load i, state SHALL become FULL.
REQ-019 Latency: result visible on m_y exactly one cycle after the accepting edge; throughput one operation per cycle when m_ready stays high.
REQ-020 FULL with m_ready=1 and no accept SHALL go to EMPTY; FULL with m_ready=0 SHALL hold m_y and m_id stable, and both s*_ready SHALL be 0.
REQ-021 Simultaneous drain and accept in the same cycle SHALL stay FULL with the new result (no bubble).
REQ-022 rr_ptr SHALL be set to the index of the requester not accepted, after every accept; it is unchanged otherwise.
REQ-023 Single requester valid SHALL be granted regardless of rr_ptr.
REQ-024 cnt0/cnt1 SHALL increment by 1 on each accept from the respective requester and wrap 255 -> 0.
REQ-025 Changes on operands while siready=0 SHALL have no effect on state.

Reset
REQ-026 While rst=1: state EMPTY, m_valid=0, m_y=0, m_id=0, rr_ptr=0, cnt0=cnt1=0, s0_ready=s1_ready=0.
REQ-027 Reset asserted mid-operation SHALL discard any held result immediately (asynchronously), with no result presented after release.
REQ-028 First edge after rst deassertion SHALL be able to accept an operation.

Verification
REQ-029 s0 only, a=15, b=4, sel=00, m_ready=1 -> next cycle m_valid=1, m_y=19, m_id=0, cnt0=1.
REQ-030 s1 only, a=4, b=15, sel=01 -> m_y=0xFFF5, m_id=1; then a=15, b=4, sel=01 -> m_y=11.
REQ-031 Both valid after reset: s0 a=0x0F0F, b=0x00FF, sel=10; s1 same operands, sel=11 -> m_y=0x000F m_id=0, next cycle m_y=0x0FFF m_id=1; rr_ptr alternates on continued contention.
REQ-032 m_ready=0 for 3 cycles with FULL -> both s*_ready=0, m_y unchanged; m_ready=1 with s0 pending -> drain and accept same edge, m_valid stays 1.
REQ-033 rst pulsed while FULL and both requesters valid -> m_valid=0, cnt0=cnt1=0 immediately; no stale result after release.
REQ-034 256 back-to-back s0 accepts -> cnt0 wraps to 0, cnt1 unchanged.
